seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_mux.sv | 83 ++++++++
 tb/tb_seg_scan_mux.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed display scanner: cycles one hex digit at a time onto a
// shared nibble bus, swapping in newly loaded values only at frame boundaries.
module seg_scan_mux #(
   parameter int unsigned CLK_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic        load,
   input  logic        lzb,
   output logic        A,
   output logic        B,
   output logic        C,
   output logic        D,
   output logic [3:0]  an,
   output logic        pending,
   output logic        tick
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic          pending_q, pending_d;
   logic [15:0]   pend_val_q, pend_val_d;
   logic [15:0]   disp_q, disp_d;
   logic [3:0]    nib_q, nib_d;
   logic [3:0]    an_q, an_d;
   logic          tick_q, tick_d;
   logic          term, wrap;
   logic [3:0]    lead_zero;

   // lead_zero[i]: every digit from i upward is zero in the next display contents
   assign lead_zero[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 4; gi++) begin : g_lz
         assign lead_zero[gi] = ~|disp_d[15:4*gi];
      end
   endgenerate

   always_comb begin
      term       = (presc_q == LAST);
      wrap       = term && (idx_q == 2'd3);
      presc_d    = term ? '0 : presc_q + 1'b1;
      idx_d      = term ? idx_q + 2'd1 : idx_q;
      tick_d     = term;
      // Transfer uses the old pending contents; a same-cycle load re-arms pending.
      disp_d     = (wrap && pending_q) ? pend_val_q : disp_q;
      pend_val_d = load ? value : pend_val_q;
      pending_d  = load | (pending_q & ~wrap);
      nib_d      = disp_d[{idx_d, 2'b00} +: 4];
      an_d       = (lzb && lead_zero[idx_d]) ? 4'b1111 : ~(4'b0001 << idx_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q    <= '0;
         idx_q      <= 2'd0;
         pending_q  <= 1'b0;
         pend_val_q <= 16'h0;
         disp_q     <= 16'h0;
         nib_q      <= 4'h0;
         an_q       <= 4'b1110;
         tick_q     <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         pending_q  <= pending_d;
         pend_val_q <= pend_val_d;
         disp_q     <= disp_d;
         nib_q      <= nib_d;
         an_q       <= an_d;
         tick_q     <= tick_d;
      end
   end

   assign {D, C, B, A} = nib_q;
   assign an           = an_q;
   assign pending      = pending_q;
   assign tick         = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised and directed checks of seg_scan_mux against a cycle-count based
// reference model; expectations are queued by the driver and consumed by a monitor.
module tb_seg_scan_mux;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] value;
   logic        load;
   logic        lzb;
   logic        A, B, C, D;
   logic [3:0]  an;
   logic        pending;
   logic        tick;

   seg_scan_mux #(.CLK_DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .load(load), .lzb(lzb),
      .A(A), .B(B), .C(C), .D(D), .an(an), .pending(pending), .tick(tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] an;
      logic [3:0] nib;
      logic       tick;
      logic       pend;
      int         cyc;
      string      phase;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   string phase = "reset";

   // Reference state: edges since reset, displayed value, pending value and flag.
   int          n = 0;
   logic [15:0] m_disp = 0;
   logic [15:0] m_pval = 0;
   bit          m_pend = 0;

   task automatic step(input bit r, input bit ld, input logic [15:0] v, input bit lz);
      exp_t e;
      int   d;
      logic [15:0] upper;
      rst_n = r; load = ld; value = v; lzb = lz;
      @(posedge clk);
      cyc++;
      if (!r) begin
         n = 0; m_disp = 0; m_pval = 0; m_pend = 0;
         e.an = 4'b1110; e.nib = 4'h0; e.tick = 1'b0; e.pend = 1'b0;
      end else begin
         n++;
         if (n % FRAME == 0) begin
            if (m_pend) m_disp = m_pval;
            m_pend = 0;
         end
         if (ld) begin
            m_pval = v;
            m_pend = 1;
         end
         d      = (n / DIV) % 4;
         upper  = m_disp >> (4 * d);
         e.nib  = upper[3:0];
         e.an   = (lz && d > 0 && upper == 16'h0) ? 4'b1111 : 4'((~(1 << d)) & 4'hF);
         e.tick = (n % DIV == 0);
         e.pend = m_pend;
      end
      e.cyc   = cyc;
      e.phase = phase;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle(input int k, input bit lz);
      for (int i = 0; i < k; i++) step(1'b1, 1'b0, 16'h0, lz);
   endtask

   // Monitor: outputs are sampled 2 time units after every rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (an !== e.an || {D, C, B, A} !== e.nib || tick !== e.tick || pending !== e.pend) begin
               bad++;
               $display("FAIL %s cyc=%0d got an=%b nib=%h tick=%b pend=%b want an=%b nib=%h tick=%b pend=%b",
                        e.phase, e.cyc, an, {D, C, B, A}, tick, pending, e.an, e.nib, e.tick, e.pend);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; load = 1'b0; value = 16'h0; lzb = 1'b0;
      phase = "reset";
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0);

      phase = "idle_scan";
      idle(40, 1'b0);

      phase = "load_1A2F";
      step(1'b1, 1'b1, 16'h1A2F, 1'b0);
      idle(40, 1'b0);

      phase = "lzb_0005";
      step(1'b1, 1'b1, 16'h0005, 1'b1);
      idle(36, 1'b1);
      phase = "lzb_0105";
      step(1'b1, 1'b1, 16'h0105, 1'b1);
      idle(36, 1'b1);

      phase = "overwrite";
      step(1'b1, 1'b1, 16'h1111, 1'b0);
      step(1'b1, 1'b1, 16'h2222, 1'b0);
      idle(36, 1'b0);

      phase = "wrap_load";
      while ((n + 1) % FRAME == 0 || (n + 1) % FRAME == 1) idle(1, 1'b0);
      step(1'b1, 1'b1, 16'h3333, 1'b0);
      while ((n + 1) % FRAME != 0) idle(1, 1'b0);
      step(1'b1, 1'b1, 16'h4444, 1'b0);
      idle(40, 1'b0);

      phase = "reset_pending";
      while (!(((n + 1) / DIV) % 4 == 2 && (n + 1) % DIV == 1)) idle(1, 1'b0);
      step(1'b1, 1'b1, 16'h5555, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      idle(40, 1'b0);

      phase = "random";
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 99) != 0, $urandom_range(0, 9) == 0,
              16'($urandom), $urandom_range(0, 1) == 1);
      idle(20, 1'b0);

      #4;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d entries left want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
